fadd_sub: RTL and testbench
===========================

Name: fadd_sub

Overview:
- IEEE-754 single-precision floating-point adder/subtractor with a registered result.
- Computes in1 + in2 (op=0) or in1 - in2 (op=1), rounding to nearest, ties-to-even.
- Supports normals, subnormals, zeros, infinities and NaN.
- Serves as the add/sub unit of the floating-point ALU; one-cycle latency, fully pipelined (new operands accepted every cycle).

Parameters:
- none (fixed 32-bit binary32 format: 1 sign, 8 exponent, 23 fraction bits, bias 127)

Ports:
- clk       input   1   rising-edge clock
- rst_n     input   1   asynchronous active-low reset
- in1       input   32  operand A (binary32)
- in2       input   32  operand B (binary32)
- op        input   1   0 = add (A+B), 1 = subtract (A-B)
- out       output  32  registered result (binary32)
- overflow  output  1   registered flag: finite operands produced a result beyond max finite

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, out=32'h00000000 and overflow=0, immediately and regardless of clk.
- Latency: in1/in2/op sampled at a rising edge; result appears on out/overflow after that same edge; held until the next edge.
- Subtraction: invert in2 sign, then perform the add.
- Unpack:
  - exp=0 gives significand {0,frac} with effective exponent 1 (subnormal).
  - Otherwise significand is {1,frac}.
- Align: swap so the larger-magnitude operand is first. Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. Shifts of 27 or more collapse entirely into sticky.
- Same effective sign: add significands. On carry-out, shift right 1 (sticky ORed) and increment exponent.
- Opposite signs: subtract smaller from larger; result takes the larger operand's sign. Normalize with a leading-zero count and left shift, but never below exponent 1; a result with exponent 1 and leading bit 0 encodes as subnormal (exp field 0).
- Rounding: round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalizes: subnormal->normal, or exponent+1.
- Overflow: final exponent >= 255 from finite operands gives out = signed infinity (sign<<31 | 7F800000) and overflow=1.
- Exact zero result:
  - Opposite-sign cancellation gives +0.
  - (-0)+(-0) gives -0; (+0)+(+0) gives +0.
- Special operands (overflow=0 in all cases):
  - Any NaN operand gives canonical quiet NaN 7FC00000.
  - Inf + Inf, same effective sign: that infinity.
  - Inf - Inf, opposite effective signs: 7FC00000.
  - Inf with a finite operand: the infinity, carrying its effective sign.
- No exception flags other than overflow; no underflow/inexact outputs.
- Combinational path between the input sampling edge and the output register must complete in one cycle; no internal state besides the output registers.

Test Plan:
- Normal mixed-sign add: in1=3C600011, in2=BE820000, op=0 -> out=BE75FFFF, overflow=0, one cycle after the sampling edge.
- Subnormal add: in1=007FFFFF, in2=007FFFFF, op=0 -> out=00FFFFFE (normal); in1=00C00000, in2=00400000, op=1 -> 00800000; in1=00C00000, in2=00800000, op=1 -> 00400000 (subnormal result).
- Infinities: 7F800000 + 7F800000 (op=0) -> 7F800000, overflow=0; same operands op=1 -> 7FC00000, overflow=0.
- Max-finite overflow and cancellation: 7F7FFFFF + 7F7FFFFF op=0 -> 7F800000, overflow=1; same operands op=1 -> 00000000, overflow=0.
- Rounding ties-to-even: 3F800000 + 33800000 (1.0 + 2^-24), op=0 -> 3F800000; 3F800001 + 33800000 -> 3F800002. NaN input 7FC12345 + 3F800000 -> 7FC00000.
- Reset: assert rst_n=0 mid-stream with non-zero out -> out=00000000, overflow=0 immediately (no clock edge). Release rst_n -> the next edge loads the current operands' result.

Source files
------------

// File: rtl/fadd_sub.sv
// IEEE-754 binary32 adder/subtractor with round-to-nearest-even and a registered result.
// One-cycle latency: operands sampled on a rising edge, result valid right after it.
module fadd_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        op,
  output logic [31:0] out,
  output logic        overflow
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] out_q, out_d;
  logic        overflow_q, overflow_d;

  // Leading-zero count of a 27-bit significand with guard/round/sticky; 27 when zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic        sa, sb, sl, ss;
  logic [7:0]  ea_f, eb_f, ea, eb, el, es, exp_diff;
  logic [23:0] ma, mb, ml, ms;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic [53:0] al_wide;
  logic [26:0] ms_al, ml_x, diff_m, norm_m;
  logic [27:0] sum_m;
  logic [4:0]  lz;
  logic [9:0]  lim, sh, e_n, e_r;
  logic        rnd_up, cancel_zero;
  logic [24:0] mr;
  logic [23:0] mant;
  logic [7:0]  exp_field;

  always_comb begin
    sa   = in1[31];
    sb   = in2[31] ^ op;
    ea_f = in1[30:23];
    eb_f = in2[30:23];
    a_nan = (&ea_f) && (|in1[22:0]);
    b_nan = (&eb_f) && (|in2[22:0]);
    a_inf = (&ea_f) && !(|in1[22:0]);
    b_inf = (&eb_f) && !(|in2[22:0]);
    ea = (ea_f == 8'd0) ? 8'd1 : ea_f;
    eb = (eb_f == 8'd0) ? 8'd1 : eb_f;
    ma = {(ea_f != 8'd0), in1[22:0]};
    mb = {(eb_f != 8'd0), in2[22:0]};

    // Magnitude order of binary32 matches unsigned order of the low 31 bits.
    swap = (in2[30:0] > in1[30:0]);
    sl = swap ? sb : sa;
    el = swap ? eb : ea;
    ml = swap ? mb : ma;
    ss = swap ? sa : sb;
    es = swap ? ea : eb;
    ms = swap ? ma : mb;

    exp_diff = el - es;
    al_wide  = {ms, 3'b000, 27'd0} >> exp_diff;
    if (exp_diff >= 8'd27) begin
      ms_al = {26'd0, |ms};
    end else begin
      ms_al = {al_wide[53:28], al_wide[27] | (|al_wide[26:0])};
    end
    ml_x = {ml, 3'b000};

    sum_m       = 28'd0;
    diff_m      = 27'd0;
    lz          = 5'd0;
    lim         = 10'd0;
    sh          = 10'd0;
    cancel_zero = 1'b0;
    if (sl == ss) begin
      sum_m = {1'b0, ml_x} + {1'b0, ms_al};
      if (sum_m[27]) begin
        norm_m = {sum_m[27:2], sum_m[1] | sum_m[0]};
        e_n    = {2'b00, el} + 10'd1;
      end else begin
        norm_m = sum_m[26:0];
        e_n    = {2'b00, el};
      end
    end else begin
      diff_m      = ml_x - ms_al;
      cancel_zero = (diff_m == 27'd0);
      lz          = lzc27(diff_m);
      // Normalisation stops at exponent 1 so tiny results fall out as subnormals.
      lim         = {2'b00, el} - 10'd1;
      sh          = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
      norm_m      = diff_m << sh;
      e_n         = {2'b00, el} - sh;
    end

    rnd_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
    mr     = {1'b0, norm_m[26:3]} + {24'd0, rnd_up};
    if (mr[24]) begin
      mant = mr[24:1];
      e_r  = e_n + 10'd1;
    end else begin
      mant = mr[23:0];
      e_r  = e_n;
    end
    exp_field = mant[23] ? e_r[7:0] : 8'd0;

    out_d      = {sl, exp_field, mant[22:0]};
    overflow_d = 1'b0;
    if (a_nan || b_nan) begin
      out_d = QNAN;
    end else if (a_inf && b_inf) begin
      out_d = (sa == sb) ? {sa, 31'h7F80_0000} : QNAN;
    end else if (a_inf) begin
      out_d = {sa, 31'h7F80_0000};
    end else if (b_inf) begin
      out_d = {sb, 31'h7F80_0000};
    end else if (cancel_zero) begin
      out_d = 32'h0000_0000;
    end else if (e_r >= 10'd255) begin
      out_d      = {sl, 31'h7F80_0000};
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= 32'h0000_0000;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fadd_sub.sv
// Randomised and directed bench for fadd_sub against an exact-arithmetic reference:
// operands become wide integers in units of 2^-149, the exact sum is rounded to binary32.
module tb_fadd_sub;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1, in2;
  logic        op;
  logic [31:0] out;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  fadd_sub dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Exact reference: value = sign * M * 2^-149, M an unbounded-enough integer.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic opi,
                       output logic [31:0] r, output logic ovf);
    logic        s_a, s_b, s_r;
    int          e_a, e_b, p, shift, expo;
    logic [299:0] m_a, m_b, m, keep, rem, half, one, mask;
    s_a = a[31];
    s_b = b[31] ^ opi;
    e_a = int'(a[30:23]);
    e_b = int'(b[30:23]);
    ovf = 1'b0;
    r   = 32'h0;
    one = 300'd1;
    if ((e_a == 255 && a[22:0] != 0) || (e_b == 255 && b[22:0] != 0)) begin
      r = 32'h7FC0_0000;
    end else if (e_a == 255 && e_b == 255) begin
      r = (s_a == s_b) ? {s_a, 31'h7F80_0000} : 32'h7FC0_0000;
    end else if (e_a == 255) begin
      r = {s_a, 31'h7F80_0000};
    end else if (e_b == 255) begin
      r = {s_b, 31'h7F80_0000};
    end else begin
      m_a = 300'({(e_a != 0), a[22:0]}) << ((e_a == 0 ? 1 : e_a) - 1);
      m_b = 300'({(e_b != 0), b[22:0]}) << ((e_b == 0 ? 1 : e_b) - 1);
      if (s_a == s_b) begin
        m = m_a + m_b;
        s_r = s_a;
      end else if (m_a >= m_b) begin
        m = m_a - m_b;
        s_r = s_a;
      end else begin
        m = m_b - m_a;
        s_r = s_b;
      end
      if (m == 0 && s_a != s_b) s_r = 1'b0;
      p = -1;
      for (int i = 0; i < 300; i++) if (m[i]) p = i;
      if (p <= 23) begin
        r = {s_r, m[30:0]};
      end else begin
        shift = p - 23;
        keep  = m >> shift;
        mask  = (one << shift) - one;
        rem   = m & mask;
        half  = one << (shift - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + one;
        if (keep == (one << 24)) begin
          keep  = keep >> 1;
          shift = shift + 1;
        end
        expo = shift + 1;
        if (expo >= 255) begin
          r   = {s_r, 31'h7F80_0000};
          ovf = 1'b1;
        end else begin
          r = {s_r, 8'(expo), keep[22:0]};
        end
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic opi,
                         input string tag);
    logic [31:0] exp_r;
    logic        exp_o;
    model(a, b, opi, exp_r, exp_o);
    in1 = a;
    in2 = b;
    op  = opi;
    @(posedge clk);
    #1;
    $display("txn %s a=%08h b=%08h op=%0d out=%08h ovf=%0d", tag, a, b, opi, out, overflow);
    chk({tag, "_out"}, out, exp_r);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_o});
  endtask

  task automatic run_fixed(input logic [31:0] a, input logic [31:0] b, input logic opi,
                           input logic [31:0] want, input logic want_ovf, input string tag);
    in1 = a;
    in2 = b;
    op  = opi;
    @(posedge clk);
    #1;
    $display("txn %s a=%08h b=%08h op=%0d out=%08h ovf=%0d", tag, a, b, opi, out, overflow);
    chk({tag, "_out"}, out, want);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, want_ovf});
  endtask

  function automatic logic [31:0] rand_operand(input int mode, input logic [31:0] other);
    logic [31:0] v;
    int          e;
    logic [31:0] specials [8];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001, 32'h7F7F_FFFF, 32'h0000_0001};
    v = $urandom;
    case (mode)
      0, 1, 2: ;
      3, 4, 5: begin
        e = int'(other[30:23]) + $urandom_range(0, 4) - 2;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
        if ($urandom_range(0, 1) == 1) v[22:0] = other[22:0] ^ (23'd1 << $urandom_range(0, 22));
      end
      6: v[30:23] = 8'($urandom_range(0, 2));
      7: v[30:23] = 8'($urandom_range(252, 254));
      default: v = specials[$urandom_range(0, 7)];
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] a, b;
    int          mode;
    rst_n = 1'b0;
    in1   = 32'h3F80_0000;
    in2   = 32'h3F80_0000;
    op    = 1'b0;
    #3;
    chk("reset_out", out, 32'h0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_fixed(32'h3C60_0011, 32'hBE82_0000, 1'b0, 32'hBE75_FFFF, 1'b0, "mixed");
    run_fixed(32'h007F_FFFF, 32'h007F_FFFF, 1'b0, 32'h00FF_FFFE, 1'b0, "sub_sum");
    run_fixed(32'h00C0_0000, 32'h0040_0000, 1'b1, 32'h0080_0000, 1'b0, "sub_diff_n");
    run_fixed(32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0040_0000, 1'b0, "sub_diff_s");
    run_fixed(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0, "inf_add");
    run_fixed(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, "inf_sub");
    run_fixed(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, "max_ovf");
    run_fixed(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h0000_0000, 1'b0, "cancel");
    run_fixed(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, "tie_even");
    run_fixed(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, "tie_odd");
    run_fixed(32'h7FC1_2345, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, "nan");
    run_fixed(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, "negzero");
    run_fixed(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, "poszero");
    run_fixed(32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 1'b0, "inf_fin");

    for (int n = 0; n < 3000; n++) begin
      mode = $urandom_range(0, 8);
      a = rand_operand((mode == 8) ? 8 : 0, 32'h0);
      b = rand_operand(mode, a);
      run_txn(a, b, 1'($urandom_range(0, 1)), "rand");
    end

    // Asynchronous reset mid-cycle, away from any clock edge.
    run_fixed(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, 1'b0, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 32'h0);
    chk("async_rst_ovf", {31'd0, overflow}, 32'd0);
    in1 = 32'h7F7F_FFFF;
    in2 = 32'h7F7F_FFFF;
    op  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_fixed(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
